ram_io_responder: RTL and testbench
===================================

Name: ram_io_responder

Overview:
- Responder end of the CPU's byte-wide memory bus (address, write strobe, data-out from CPU; data-in returned to CPU).
- Services 128KB of byte RAM.
- Services the memory-mapped I/O window at a[17:16]==2'b11:
  - UART TX byte FIFO with the io_buffer_full back-pressure flag.
  - Free-running cycle counter, readable as 4 bytes.
  - Program-stop register.
- Sits directly below the CPU's memory controller; replaces the external RAM/HCI model for simulation and FPGA builds.

Parameters:
- RAM_ADDR_WIDTH, 17, byte address bits for RAM (2^17 = 128KB).
- TX_FIFO_DEPTH_LOG, 4, log2 of TX FIFO depth (16 entries).
- FULL_SLACK, 2, free-entry count at or below which io_buffer_full asserts.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  CPU ready; when low, all CPU-facing state freezes
- cpu_a  in  32  byte address from CPU (only [17:0] decoded)
- cpu_wr  in  1  1 = write, 0 = read
- cpu_dout  in  8  write data from CPU
- cpu_din  out  8  read data to CPU, registered
- io_buffer_full  out  1  TX FIFO nearly full; CPU must stall I/O writes
- uart_tx_valid  out  1  TX FIFO non-empty
- uart_tx_data  out  8  TX FIFO head byte
- uart_tx_ready  in  1  UART accepts head byte this cycle
- uart_rx_valid  in  1  received byte available (IO_RX_EN only)
- uart_rx_data  in  8  received byte (IO_RX_EN only)
- uart_rx_pop  out  1  consume received byte, 1-cycle pulse (IO_RX_EN only)
- halted  out  1  sticky; set by the program-stop write
- tx_overflow  out  1  sticky; a TX push was dropped because the FIFO was full

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: cpu_din=0, FIFO empty (uart_tx_valid=0, uart_tx_data=0), io_buffer_full=0, uart_rx_pop=0, halted=0, tx_overflow=0, cycle counter=0, snapshot=0. RAM contents are not reset.
- Address decode:
  - IO when cpu_a[17:16]==2'b11.
  - Otherwise RAM at cpu_a[RAM_ADDR_WIDTH-1:0].
- Every access phase applies only when rdy=1. With rdy=0: no RAM/IO side effects, cpu_din holds, counter holds. The TX drain side keeps running.
- RAM read: cpu_din <= mem[a] at the next edge (1-cycle latency).
- RAM write: mem[a] <= cpu_dout at the same edge; cpu_din unchanged.
- IO read 0x30000: cpu_din <= 0 (without IO_RX_EN).
- IO read 0x30004..0x30007: cpu_din <= byte a[1:0] of a 32-bit snapshot, little-endian.
  - A read of 0x30004 returns counter[7:0] directly and loads snapshot <= counter in the same edge.
  - Reads of 0x30005..7 return snapshot bytes, so the 4-byte read is coherent.
- Other IO read addresses: cpu_din <= 0.
- IO write 0x30000:
  - Non-zero byte is pushed to the TX FIFO.
  - 0x00 is ignored.
- IO write 0x30004: pushes 0x00 to the TX FIFO (stop marker) and sets halted=1.
- While halted=1: all further CPU writes are ignored and the counter freezes. Reads still serviced.
- Other IO write addresses: no effect.
- Cycle counter: +1 every cycle with rdy=1 and halted=0; wraps 0xFFFFFFFF -> 0.
- TX FIFO:
  - Circular buffer with head/tail pointers and a (TX_FIFO_DEPTH_LOG+1)-bit count.
  - uart_tx_valid = (count != 0); uart_tx_data = mem[head].
  - Pop on uart_tx_valid && uart_tx_ready.
  - Simultaneous push and pop: both occur, count unchanged, including at count = DEPTH.
  - Push when count == DEPTH with no pop the same cycle: byte dropped, tx_overflow <= 1.
  - Pointers wrap modulo DEPTH.
- io_buffer_full: registered, = (DEPTH - next_count) <= FULL_SLACK. The slack covers one in-flight CPU write after assertion.
- Reset mid-operation: FIFO contents discarded and pointers cleared the same edge; a concurrent CPU write is ignored.

Optional Feature:
- Macro: IO_RX_EN.
- Defined: an IO read of 0x30000 returns uart_rx_data if uart_rx_valid=1, else 0. uart_rx_pop pulses high for 1 cycle on the edge that registers a valid byte.
- Undefined: 0x30000 reads return 0, uart_rx_pop is tied 0, and uart_rx_valid/uart_rx_data are ignored.

Test Plan:
- RAM round trip: write 0xA5 @0x00010, then read @0x00010 -> cpu_din=0xA5 one cycle after the read. Assert rdy=0 during the read cycle -> cpu_din unchanged until rdy=1.
- TX path: write 0x41, 0x00, 0x42 to 0x30000 with uart_tx_ready=1 -> uart_tx_data emits 0x41 then 0x42 only; the FIFO never holds 0x00.
- Back-pressure: uart_tx_ready=0, write 14 bytes -> io_buffer_full=1 after the 14th push. Write 3 more -> 2 accepted (count=16), 1 dropped, tx_overflow=1. Then uart_tx_ready=1 -> 16 bytes drained in order and io_buffer_full drops.
- Counter snapshot: after 0x12345 rdy cycles, read 0x30004..0x30007 on consecutive cycles -> bytes 0x45, 0x23, 0x01, 0x00 (snapshot coherent despite the counter advancing).
- Halt: write 0x30004 -> halted=1 and 0x00 appears on uart_tx_data. A subsequent RAM write @0x20 is not performed (read back returns the old value) and the counter holds.
- Reset mid-drain: 5 bytes queued, rst=1 for 1 cycle -> uart_tx_valid=0, halted=0, io_buffer_full=0, counter=0.

Source files
------------

// File: rtl/ram_io_responder.sv
// Byte-wide memory responder: 128KB RAM plus an I/O window (UART TX FIFO, cycle counter, program stop).
// Define IO_RX_EN to let reads of 0x30000 return received UART bytes and pulse uart_rx_pop.
module ram_io_responder #(
    parameter int RAM_ADDR_WIDTH    = 17,
    parameter int TX_FIFO_DEPTH_LOG = 4,
    parameter int FULL_SLACK        = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic        uart_tx_valid,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_ready,
    input  logic        uart_rx_valid,
    input  logic [7:0]  uart_rx_data,
    output logic        uart_rx_pop,
    output logic        halted,
    output logic        tx_overflow
);
    localparam int DEPTH = 1 << TX_FIFO_DEPTH_LOG;
    localparam int CW    = TX_FIFO_DEPTH_LOG + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] SLACK_C = CW'(FULL_SLACK);

    logic [7:0] ram [0:(2**RAM_ADDR_WIDTH)-1];
    logic [7:0] tx_mem [0:DEPTH-1];
    logic [TX_FIFO_DEPTH_LOG-1:0] head, tail;
    logic [CW-1:0] count, next_count;
    logic [31:0] counter, snapshot;
    logic [17:0] io_addr;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic is_io, rd_req, wr_req, ram_we, push_req, push, pop;
    logic [7:0] push_data, io_rdata;
    logic unused_hi;

    assign io_addr  = cpu_a[17:0];
    assign ram_idx  = cpu_a[RAM_ADDR_WIDTH-1:0];
    assign is_io    = (cpu_a[17:16] == 2'b11);
    assign rd_req   = rdy && !cpu_wr;
    assign wr_req   = rdy && cpu_wr && !halted;
    assign ram_we   = wr_req && !is_io;
    assign push_req = wr_req && is_io &&
                      (((io_addr == 18'h30000) && (cpu_dout != 8'h00)) || (io_addr == 18'h30004));
    assign push_data = (io_addr == 18'h30004) ? 8'h00 : cpu_dout;
    assign pop      = (count != '0) && uart_tx_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push     = push_req && ((count != DEPTH_C) || pop);

    assign uart_tx_valid = (count != '0);
    assign uart_tx_data  = uart_tx_valid ? tx_mem[head] : 8'h00;

    always_comb begin
        next_count = count;
        if (push && !pop)
            next_count = count + 1'b1;
        else if (pop && !push)
            next_count = count - 1'b1;
    end

    // Byte 0 of the counter window reads live; bytes 1..3 come from the snapshot it takes.
    always_comb begin
        io_rdata = 8'h00;
        if (io_addr[17:2] == 16'hC001) begin
            case (io_addr[1:0])
                2'd0:    io_rdata = counter[7:0];
                2'd1:    io_rdata = snapshot[15:8];
                2'd2:    io_rdata = snapshot[23:16];
                default: io_rdata = snapshot[31:24];
            endcase
        end
`ifdef IO_RX_EN
        else if ((io_addr == 18'h30000) && uart_rx_valid) begin
            io_rdata = uart_rx_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_din        <= 8'h00;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            io_buffer_full <= 1'b0;
            halted         <= 1'b0;
            tx_overflow    <= 1'b0;
            counter        <= 32'h0;
            snapshot       <= 32'h0;
        end else begin
            if (rd_req)
                cpu_din <= is_io ? io_rdata : ram[ram_idx];
            if (rd_req && is_io && (io_addr == 18'h30004))
                snapshot <= counter;
            if (rdy && !halted)
                counter <= counter + 32'd1;
            if (wr_req && is_io && (io_addr == 18'h30004))
                halted <= 1'b1;
            if (push_req && !push)
                tx_overflow <= 1'b1;
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            count          <= next_count;
            io_buffer_full <= ((DEPTH_C - next_count) <= SLACK_C);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && ram_we)
            ram[ram_idx] <= cpu_dout;
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            tx_mem[tail] <= push_data;
    end

`ifdef IO_RX_EN
    always_ff @(posedge clk) begin
        if (rst)
            uart_rx_pop <= 1'b0;
        else
            uart_rx_pop <= rd_req && (io_addr == 18'h30000) && uart_rx_valid;
    end
    assign unused_hi = ^cpu_a[31:18];
`else
    assign uart_rx_pop = 1'b0;
    assign unused_hi   = ^{cpu_a[31:18], uart_rx_valid, uart_rx_data};
`endif
endmodule

// File: tb/tb_ram_io_responder.sv
// Self-checking bench for ram_io_responder: directed scenarios plus random traffic against a
// queue/associative-array reference model.
module tb_ram_io_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic [31:0] cpu_a = 32'h0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_dout = 8'h0;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic        uart_tx_valid;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_ready = 1'b0;
    logic        uart_rx_valid = 1'b0;
    logic [7:0]  uart_rx_data = 8'h0;
    logic        uart_rx_pop;
    logic        halted;
    logic        tx_overflow;

    ram_io_responder dut (
        .clk(clk), .rst(rst), .rdy(rdy), .cpu_a(cpu_a), .cpu_wr(cpu_wr),
        .cpu_dout(cpu_dout), .cpu_din(cpu_din), .io_buffer_full(io_buffer_full),
        .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data),
        .uart_tx_ready(uart_tx_ready), .uart_rx_valid(uart_rx_valid),
        .uart_rx_data(uart_rx_data), .uart_rx_pop(uart_rx_pop),
        .halted(halted), .tx_overflow(tx_overflow)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [7:0]  ram_m [int];
    logic [7:0]  q_m [$];
    logic [31:0] cnt_m = 0;
    logic [31:0] snap_m = 0;
    logic [7:0]  din_m = 0;
    bit          din_known = 0;
    bit          halted_m = 0, ovf_m = 0, full_m = 0, rxpop_m = 0;

    logic [17:0] pool [12] = '{18'h00010, 18'h00020, 18'h00000, 18'h1FFFF, 18'h1FFF0, 18'h0ABCD,
                               18'h10000, 18'h20005, 18'h00007, 18'h12345, 18'h00100, 18'h0FFFF};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model by the same edge, optionally compare everything.
    task automatic applyStimulus(input bit r, input bit ry, input logic [31:0] a, input bit w,
                                 input logic [7:0] d, input bit trdy, input bit chk);
        bit io, push_req, pop_m, halt_next;
        logic [17:0] off;
        logic [7:0] pd;
        int idx;
        @(negedge clk);
        rst = r; rdy = ry; cpu_a = a; cpu_wr = w; cpu_dout = d; uart_tx_ready = trdy;
        uart_rx_valid = 1'($urandom_range(0, 1));
        uart_rx_data  = 8'($urandom_range(0, 255));
        if (r) begin
            q_m.delete();
            din_m = 0; din_known = 1; cnt_m = 0; snap_m = 0;
            halted_m = 0; ovf_m = 0; full_m = 0; rxpop_m = 0;
        end else begin
            io = (a[17:16] == 2'b11);
            off = a[17:0];
            idx = int'(a[16:0]);
            pop_m = (q_m.size() != 0) && trdy;
            push_req = 0; halt_next = 0; pd = 0; rxpop_m = 0;
            if (ry) begin
                if (!w) begin
                    if (!io) begin
                        din_known = ram_m.exists(idx);
                        if (din_known) din_m = ram_m[idx];
                    end else begin
                        din_known = 1;
                        din_m = 0;
                        if (off == 18'h30004) begin
                            din_m = cnt_m[7:0];
                            snap_m = cnt_m;
                        end else if (off >= 18'h30005 && off <= 18'h30007) begin
                            din_m = 8'(snap_m >> (8 * off[1:0]));
                        end else if (off == 18'h30000) begin
`ifdef IO_RX_EN
                            if (uart_rx_valid) begin
                                din_m = uart_rx_data;
                                rxpop_m = 1;
                            end
`endif
                        end
                    end
                end else if (!halted_m) begin
                    if (!io) ram_m[idx] = d;
                    else if (off == 18'h30000 && d != 0) begin push_req = 1; pd = d; end
                    else if (off == 18'h30004) begin push_req = 1; pd = 0; halt_next = 1; end
                end
                if (!halted_m) cnt_m = cnt_m + 1;
            end
            if (pop_m) void'(q_m.pop_front());
            if (push_req) begin
                if (q_m.size() < 16) q_m.push_back(pd);
                else ovf_m = 1;
            end
            if (halt_next) halted_m = 1;
            full_m = ((16 - q_m.size()) <= 2);
        end
        @(posedge clk);
        #1;
        if (chk) begin
            if (din_known) checkOutput("cpu_din", cpu_din, din_m);
            checkOutput("tx_valid", uart_tx_valid, q_m.size() != 0);
            checkOutput("tx_data", uart_tx_data, (q_m.size() != 0) ? q_m[0] : 8'h00);
            checkOutput("buf_full", io_buffer_full, full_m);
            checkOutput("halted", halted, halted_m);
            checkOutput("tx_overflow", tx_overflow, ovf_m);
            checkOutput("rx_pop", uart_rx_pop, rxpop_m);
        end
    endtask

    initial begin
        logic [7:0] sent [$];
        logic [7:0] old_val, b;
        logic [31:0] hi, cnt_at_halt;
        int k;

        // Reset state
        applyStimulus(1, 1, 32'h0, 0, 0, 0, 0);
        applyStimulus(1, 1, 32'h0, 0, 0, 0, 1);
        checkOutput("rst_din", cpu_din, 8'h00);
        checkOutput("rst_valid", uart_tx_valid, 1'b0);

        // Preload the RAM pool so every later pool read has a known value
        foreach (pool[i]) applyStimulus(0, 1, {14'h0, pool[i]}, 1, 8'($urandom_range(0, 255)), 1, 1);

        // RAM round trip, with a stalled read in between
        applyStimulus(0, 1, 32'h10, 1, 8'hA5, 1, 1);
        applyStimulus(0, 1, 32'h20, 0, 0, 1, 1);
        applyStimulus(0, 0, 32'h10, 0, 0, 1, 1);
        checkOutput("rdy_low_hold", cpu_din, ram_m[32]);
        applyStimulus(0, 1, 32'h10, 0, 0, 1, 1);
        checkOutput("ram_rt", cpu_din, 8'hA5);

        // TX path: zero bytes never enter the FIFO
        applyStimulus(0, 1, 32'h30000, 1, 8'h41, 1, 1);
        checkOutput("tx_first", uart_tx_data, 8'h41);
        applyStimulus(0, 1, 32'h30000, 1, 8'h00, 1, 1);
        checkOutput("tx_zero_skip", uart_tx_valid, 1'b0);
        applyStimulus(0, 1, 32'h30000, 1, 8'h42, 1, 1);
        checkOutput("tx_second", uart_tx_data, 8'h42);
        applyStimulus(0, 1, 32'h10, 0, 0, 1, 1);

        // Back-pressure and overflow
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom_range(1, 255));
            if (i < 16) sent.push_back(b);
            applyStimulus(0, 1, 32'h30000, 1, b, 0, 1);
            if (i == 12) checkOutput("full_13", io_buffer_full, 1'b0);
            if (i == 13) checkOutput("full_14", io_buffer_full, 1'b1);
            if (i == 15) checkOutput("ovf_16", tx_overflow, 1'b0);
        end
        checkOutput("ovf_17", tx_overflow, 1'b1);
        for (int i = 0; i < 16; i++) begin
            checkOutput("drain_order", uart_tx_data, sent[i]);
            applyStimulus(0, 1, 32'h10, 0, 0, 1, 1);
        end
        checkOutput("drain_empty", uart_tx_valid, 1'b0);
        checkOutput("drain_full", io_buffer_full, 1'b0);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            hi = $urandom();
            k = $urandom_range(0, 99);
            if (k < 45)
                applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 85,
                              {hi[13:0], pool[$urandom_range(0, 11)]}, 1'($urandom_range(0, 1)),
                              8'($urandom_range(0, 255)), $urandom_range(0, 99) < 40, 1);
            else if (k < 70)
                applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 85,
                              {hi[13:0], 18'h30000}, 1,
                              ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
                              $urandom_range(0, 99) < 40, 1);
            else if (k < 90)
                applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 85,
                              {hi[13:0], 18'h30000 + 18'($urandom_range(0, 9))}, 0, 0,
                              $urandom_range(0, 99) < 40, 1);
            else if (k < 93)
                applyStimulus(0, 1, {hi[13:0], 18'h30008 - 18'($urandom_range(1, 3))}, 1,
                              8'($urandom_range(0, 255)), $urandom_range(0, 99) < 40, 1);
            else if (k < 94)
                applyStimulus(0, 1, 32'h30004, 1, 0, $urandom_range(0, 99) < 40, 1);
            else
                applyStimulus(0, 1, 32'h10, 0, 0, $urandom_range(0, 99) < 40, 1);
        end

        // Coherent counter snapshot after 0x12345 counted cycles
        applyStimulus(1, 1, 32'h10, 0, 0, 1, 1);
        for (int i = 0; i < 32'h12345; i++) applyStimulus(0, 1, 32'h10, 0, 0, 1, 0);
        applyStimulus(0, 1, 32'h30004, 0, 0, 1, 1);
        checkOutput("snap_b0", cpu_din, 8'h45);
        applyStimulus(0, 1, 32'h30005, 0, 0, 1, 1);
        checkOutput("snap_b1", cpu_din, 8'h23);
        applyStimulus(0, 1, 32'h30006, 0, 0, 1, 1);
        checkOutput("snap_b2", cpu_din, 8'h01);
        applyStimulus(0, 1, 32'h30007, 0, 0, 1, 1);
        checkOutput("snap_b3", cpu_din, 8'h00);

        // Halt: stop marker queued, later writes ignored, counter frozen
        applyStimulus(1, 1, 32'h10, 0, 0, 1, 1);
        old_val = ram_m[32];
        applyStimulus(0, 1, 32'h30004, 1, 8'h5A, 0, 1);
        cnt_at_halt = cnt_m;
        checkOutput("halt_set", halted, 1'b1);
        checkOutput("halt_marker_v", uart_tx_valid, 1'b1);
        checkOutput("halt_marker_d", uart_tx_data, 8'h00);
        applyStimulus(0, 1, 32'h20, 1, ~old_val, 0, 1);
        applyStimulus(0, 1, 32'h20, 0, 0, 0, 1);
        checkOutput("halt_ram_kept", cpu_din, old_val);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 32'h10, 0, 0, 0, 1);
        applyStimulus(0, 1, 32'h30004, 0, 0, 0, 1);
        checkOutput("halt_cnt_frozen", cpu_din, cnt_at_halt[7:0]);

        // Reset in the middle of a drain
        applyStimulus(1, 1, 32'h10, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 32'h30000, 1, 8'(i + 1), 0, 1);
        applyStimulus(0, 1, 32'h30004, 1, 0, 0, 1);
        applyStimulus(0, 1, 32'h10, 0, 0, 1, 1);
        applyStimulus(1, 1, 32'h30000, 1, 8'h33, 1, 1);
        checkOutput("mid_rst_valid", uart_tx_valid, 1'b0);
        checkOutput("mid_rst_halted", halted, 1'b0);
        checkOutput("mid_rst_full", io_buffer_full, 1'b0);
        applyStimulus(0, 1, 32'h30004, 0, 0, 1, 1);
        checkOutput("mid_rst_cnt", cpu_din, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
